// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared 8-to-1 single-bit mux.
// Grant tenure is bounded under contention; the selected data bit is registered onto y.
module rr_mux_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] din,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       y
);

   localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_e;

   state_e        state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    gnt_q, gnt_d;
   logic          busy_q, busy_d;
   logic          y_q, y_d;
   logic [7:0]    others_c;
   logic          release_c;

   // First set bit of mask scanning start, start+1, ... with modulo-8 wrap.
   function automatic logic [2:0] pick(input logic [7:0] mask, input logic [2:0] start);
      logic [2:0] idx;
      logic [2:0] res;
      res = start;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         if (mask[idx]) res = idx;
      end
      return res;
   endfunction

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      y_d       = busy_q ? din[sel_q] : 1'b0;
      others_c  = req & ~(8'(1) << sel_q);
      release_c = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req != 8'h00) begin
               sel_d   = pick(req, ptr_q);
               gnt_d   = 8'(1) << pick(req, ptr_q);
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            release_c = !req[sel_q] || ((cnt_q == CNT_MAX) && (others_c != 8'h00));
            if (release_c) begin
               ptr_d = sel_q + 3'd1;
               if (others_c != 8'h00) begin
                  // back-to-back handover, no idle cycle between grantees
                  sel_d = pick(others_c, sel_q + 3'd1);
                  gnt_d = 8'(1) << pick(others_c, sel_q + 3'd1);
                  cnt_d = '0;
               end else begin
                  gnt_d   = 8'h00;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= 3'd0;
         sel_q   <= 3'd0;
         cnt_q   <= '0;
         gnt_q   <= 8'h00;
         busy_q  <= 1'b0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         y_q     <= y_d;
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;
   assign y    = y_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances checked every cycle
// against a behavioural round-robin model, plus directed literal expectations.
module tb_rr_mux_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_a, din_a, req_b, din_b;
   logic [7:0] gnt_a, gnt_b;
   logic [2:0] sel_a, sel_b;
   logic       busy_a, busy_b, y_a, y_b;

   int checks = 0;
   int errors = 0;

   // model state per instance: 0 -> MAX_HOLD=4, 1 -> MAX_HOLD=1
   int m_own[2];
   int m_ptr[2];
   int m_held[2];
   bit m_busy[2];
   bit m_y[2];
   int hold_lim[2] = '{4, 1};

   rr_mux_arbiter #(.MAX_HOLD(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .din(din_a),
      .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .y(y_a)
   );

   rr_mux_arbiter #(.MAX_HOLD(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .din(din_b),
      .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .y(y_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int scan(input logic [7:0] m, input int p);
      for (int k = 0; k < 8; k++) begin
         if (m[(p + k) % 8]) return (p + k) % 8;
      end
      return p;
   endfunction

   task automatic model_reset(input int u);
      m_own[u]  = 0;
      m_ptr[u]  = 0;
      m_held[u] = 0;
      m_busy[u] = 1'b0;
      m_y[u]    = 1'b0;
   endtask

   task automatic model_step(input int u, input logic [7:0] r, input logic [7:0] d);
      logic [7:0] others;
      bit contend, rel;
      m_y[u] = m_busy[u] ? d[m_own[u]] : 1'b0;
      if (!m_busy[u]) begin
         if (r != 8'h00) begin
            m_own[u]  = scan(r, m_ptr[u]);
            m_busy[u] = 1'b1;
            m_held[u] = 1;
         end
      end else begin
         others = r;
         others[m_own[u]] = 1'b0;
         contend = (others != 8'h00);
         rel = !r[m_own[u]] || (contend && m_held[u] >= hold_lim[u]);
         if (rel) begin
            m_ptr[u] = (m_own[u] + 1) % 8;
            if (contend) begin
               m_own[u]  = scan(others, m_ptr[u]);
               m_held[u] = 1;
            end else begin
               m_busy[u] = 1'b0;
            end
         end else begin
            m_held[u] = m_held[u] + 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [7:0] eg;
      eg = m_busy[0] ? 8'(1) << m_own[0] : 8'h00;
      check("gnt_a", gnt_a, eg);
      check("sel_a", 8'(sel_a), 8'(m_own[0]));
      check("busy_a", 8'(busy_a), 8'(m_busy[0]));
      check("y_a", 8'(y_a), 8'(m_y[0]));
      eg = m_busy[1] ? 8'(1) << m_own[1] : 8'h00;
      check("gnt_b", gnt_b, eg);
      check("sel_b", 8'(sel_b), 8'(m_own[1]));
      check("busy_b", 8'(busy_b), 8'(m_busy[1]));
      check("y_b", 8'(y_b), 8'(m_y[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         model_step(0, req_a, din_a);
         model_step(1, req_b, din_b);
      end
      @(negedge clk);
      compare_all();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      #1;
      check("rst_async_gnt", gnt_a, 8'h00);
      check("rst_async_busy", 8'(busy_a), 8'h00);
      check("rst_async_sel", 8'(sel_a), 8'h00);
      check("rst_async_y", 8'(y_a), 8'h00);
      compare_all();
      tick();
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
      rst_n = 1'b1;
      req_a = 8'hFF; din_a = 8'hFF;
      req_b = 8'hFF; din_b = 8'hFF;
      #1 rst_n = 1'b0;

      // reset held with everything requesting
      tick();
      tick();
      check("rst_gnt", gnt_a, 8'h00);
      check("rst_sel", 8'(sel_a), 8'h00);
      check("rst_busy", 8'(busy_a), 8'h00);
      check("rst_y", 8'(y_a), 8'h00);
      rst_n = 1'b1;

      // full contention: 0..7,0, four cycles each
      for (int t = 0; t < 36; t++) begin
         tick();
         check("rot_gnt", gnt_a, 8'(1) << ((t / 4) % 8));
         check("rot_busy", 8'(busy_a), 8'h01);
      end

      async_reset();
      req_a = 8'h08;
      req_b = 8'h06;
      rst_n = 1'b1;

      // single requester holds indefinitely; MAX_HOLD=1 instance alternates
      for (int i = 0; i < 6; i++) begin
         tick();
         check("single_gnt", gnt_a, 8'h08);
         check("single_sel", 8'(sel_a), 8'h03);
         check("single_busy", 8'(busy_a), 8'h01);
         check("alt_gnt_b", gnt_b, (i % 2 == 0) ? 8'h02 : 8'h04);
      end
      req_a = 8'h00;
      tick();
      check("drop_gnt", gnt_a, 8'h00);
      check("drop_busy", 8'(busy_a), 8'h00);
      check("alt_gnt_b", gnt_b, 8'h02);
      req_a = 8'hFF;
      req_b = 8'h04;
      tick();
      check("ptr4_gnt", gnt_a, 8'h10);
      check("early_rel_b", gnt_b, 8'h04);
      req_b = 8'h00;

      // wrap-around: grant 6 leaves ptr at 7
      req_a = 8'h00; tick();
      req_a = 8'h40; tick();
      check("g6_gnt", gnt_a, 8'h40);
      req_a = 8'h00; tick();
      req_a = 8'h81;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("wrap7_gnt", gnt_a, 8'h80);
      end
      tick();
      check("wrap0_gnt", gnt_a, 8'h01);
      req_a = 8'h01;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("hold0_gnt", gnt_a, 8'h01);
      end

      // data path on channel 5
      req_a = 8'h00; tick();
      tick();
      check("idle_y", 8'(y_a), 8'h00);
      din_a = 8'h20; req_a = 8'h20;
      tick();
      check("g5_gnt", gnt_a, 8'h20);
      check("g5_sel", 8'(sel_a), 8'h05);
      tick();
      check("dp_y1", 8'(y_a), 8'h01);
      din_a = 8'h10; tick();
      check("dp_y0", 8'(y_a), 8'h00);
      din_a = 8'h30; tick();
      check("dp_y1b", 8'(y_a), 8'h01);
      req_a = 8'h00; tick();
      check("dp_last_y", 8'(y_a), 8'h01);
      tick();
      check("dp_idle_y", 8'(y_a), 8'h00);

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 3) == 0) req_a = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 2) == 0) req_b = 8'($urandom) & 8'($urandom);
         din_a = 8'($urandom);
         din_b = 8'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            async_reset();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared 8-to-1 single-bit multiplexer datapath. It accepts up to eight requesters, grants exactly one at a time, and drives the mux select from the grant. It registers the selected input bit as the shared output. The block bounds grant tenure under contention so no requester is starved.

## Interface
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held while another request is pending; legal range 1..16
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  request per channel; requester holds high until it is done
- din  input  8  data bits; din[i] belongs to channel i (mux inputs I0..I7)
- gnt  output  8  one-hot grant, registered; all zero when idle
- sel  output  3  registered mux select, binary index of the granted channel
- busy  output  1  registered; high while in GRANT
- y  output  1  registered shared output: din[sel] of the current grantee

## Operation
- Two states: IDLE and GRANT.
- Internal state:
  - ptr[2:0]: highest-priority channel for the next selection.
  - cnt: tenure counter, width max(1, clog2(MAX_HOLD)).
- Selection function pick(mask, ptr): the first set bit of mask scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1, with modulo-8 wrap.
- IDLE:
  - gnt=0 and busy=0.
  - If req!=0: gnt<=onehot(pick(req,ptr)), sel<=index, cnt<=0, go to GRANT.
  - If req==0: hold all state.
- GRANT, current channel c=sel, others = req with bit c cleared:
  - Release condition: req[c]==0, or (cnt==MAX_HOLD-1 and others!=0).
  - On release, ptr<=c+1 mod 8 (7 wraps to 0).
  - On release with others!=0: grant pick(others, c+1) back-to-back at the same edge, with no idle cycle; cnt<=0.
  - On release with others==0: go to IDLE; gnt<=0, busy<=0.
  - No release: keep the grant. cnt<=cnt+1, saturating at MAX_HOLD-1.
  - Saturated cnt with no contention holds the grant indefinitely.
- MAX_HOLD=1: under contention, the grant rotates every cycle.
- Output path: every edge, y<=busy ? din[sel] : 0, using the pre-edge values of busy and sel.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt==onehot(sel) whenever busy=1.
  - sel holds its last value in IDLE.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately without a clock edge):
  - gnt=0, sel=0, busy=0, y=0, ptr=0, cnt=0, state IDLE.
- Reset asserted mid-grant aborts the tenure at once, with no release bookkeeping.
- Once rst_n rises, the first edge operates normally.
- Grant latency: req sampled at edge k appears on gnt/sel/busy after edge k.
- Data latency: y reflects din[sel] sampled at edge k+1, so y is valid one cycle after gnt.
- Release by req drop: req[c] low before edge k removes the grant (or switches it) after edge k.
- The shared output y shows the last bit of the old grantee for one cycle after a switch.
- Simultaneous events:
  - req[c] drop at the same edge cnt reaches MAX_HOLD-1: one release.
  - New requests arriving in the same cycle as a release are eligible for that release's pick.
- A request that deasserts before being granted is simply dropped; no memory.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF, din=8'hFF.
  - Required: gnt=0, sel=0, busy=0, y=0.
  - Assert rst_n=0 mid-grant between edges: outputs go to 0 immediately.
  - After release with req=8'hFF: first grant is gnt=8'h01.
- Single requester: req=8'h08 for 6 cycles, MAX_HOLD=4.
  - Required: gnt=8'h08, sel=3, busy=1 for all 6 cycles (no forced release).
  - Drop req: IDLE after the next edge.
  - Then req=8'hFF: grants channel 4 (ptr=4).
- Full contention: req=8'hFF from reset, MAX_HOLD=4.
  - Required: grants 0,1,...,7,0 in sequence, 4 cycles each, back-to-back, busy never drops.
- Wrap-around: ptr=7 set via prior grant of 6, then req=8'h81.
  - Required: grants 7, then 0.
  - Then req=8'h01 only: channel 0 holds; gnt=8'h01.
- Data path: grant channel 5, din toggles 8'h20 -> 8'h10 -> 8'h30.
  - Required: y=1, 0, 1, each one cycle after the corresponding din change.
  - y=0 the cycle after entering IDLE.
- Early release and MAX_HOLD=1 (separate build):
  - req=8'h06 with MAX_HOLD=1: gnt alternates 8'h02/8'h04 every cycle.
  - Drop req[1] during its grant: channel 2 is granted at the next edge.
